// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor with valid/ready
// handshaking on both sides. The carry chain is cut into STAGES chunks of
// CW = WIDTH/STAGES bits, with one register per chunk. The last register is
// the output register and also holds the result flags.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   STAGES pipeline depth; WIDTH must be a multiple of STAGES
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, sub: 0 = a+b, 1 = a-b)
//   out_valid/out_ready result handshake
//   result              sum/difference
//   cout, ovf           raw carry out of the MSB, signed overflow
//   zero, neg           result == 0, result MSB
//
// Optional build macro:
//   ADDSUB_SAT_EN  clamp result to the signed limit on overflow
//                  (cout/ovf still report the raw condition).
module addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers. Operand B is stored already inverted for
    // subtraction, so only the carry has to travel with it.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  r_q     [STAGES];
    logic [WIDTH-1:0]  r_d     [STAGES];
    logic              carry_q [STAGES];
    logic              carry_d [STAGES];

    // Stage inputs: stage 0 is fed from the ports, stage i from register i-1.
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_r [STAGES];
    logic              src_c [STAGES];
    logic [STAGES-1:0] src_v;
    logic [CW:0]       csum  [STAGES];

    // Output register
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] raw;
    logic             msb_cin;
    logic             adv;

    // Whole pipeline moves in lock-step; a stalled output freezes every stage.
    assign adv      = !valid_q[LAST] || out_ready;
    assign in_ready = adv;

    always_comb begin
        src_a[0] = a;
        src_b[0] = b ^ {WIDTH{sub}};
        src_r[0] = '0;
        src_c[0] = sub;
        src_v[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            src_a[i] = a_q[i-1];
            src_b[i] = b_q[i-1];
            src_r[i] = r_q[i-1];
            src_c[i] = carry_q[i-1];
            src_v[i] = valid_q[i-1];
        end

        for (int i = 0; i < STAGES; i++) begin
            csum[i] = {1'b0, src_a[i][i*CW +: CW]}
                    + {1'b0, src_b[i][i*CW +: CW]}
                    + {{CW{1'b0}}, src_c[i]};
            r_d[i]              = src_r[i];
            r_d[i][i*CW +: CW]  = csum[i][CW-1:0];
            carry_d[i]          = csum[i][CW];
            a_d[i]              = src_a[i];
            b_d[i]              = src_b[i];
            valid_d[i]          = src_v[i];
        end

        raw = r_d[LAST];
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        msb_cin = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ raw[WIDTH-1];
        cout_d  = carry_d[LAST];
        ovf_d   = msb_cin ^ carry_d[LAST];

`ifdef ADDSUB_SAT_EN
        res_d = raw;
        // Raw MSB set on overflow means the true result was positive.
        if (ovf_d) begin
            res_d = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                 : {1'b1, {(WIDTH-1){1'b0}}};
        end
`else
        res_d = raw;
`endif

        zero_d = (res_d == '0);
        neg_d  = res_d[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                r_q[i]     <= '0;
                carry_q[i] <= 1'b0;
            end
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_d;
            // Data registers only load for real beats; bubbles leave them idle.
            for (int i = 0; i < STAGES; i++) begin
                if (src_v[i]) begin
                    a_q[i]     <= a_d[i];
                    b_q[i]     <= b_d[i];
                    r_q[i]     <= r_d[i];
                    carry_q[i] <= carry_d[i];
                end
            end
            if (src_v[LAST]) begin
                res_q  <= res_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                neg_q  <= neg_d;
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign result    = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed self-checking bench for addsub_pipe
// (WIDTH=32, STAGES=4). Honours ADDSUB_SAT_EN for overflow expectations.
module tb_addsub_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         cout, ovf, zero, neg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    // Drives one beat into an idle pipe and waits (bounded) for its result.
    // lat = edges after the acceptance edge until out_valid is seen.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic isub, output int lat);
        @(negedge clk);
        a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, result, cout, ovf, zero, neg} !== {1'b0, 32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b r=%h flags=%b, want v=0 r=0 flags=0000",
                     out_valid, result, {cout, ovf, zero, neg});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int lat;
        run_op(32'h00000021, 32'h00000022, 1'b0, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 3", lat);
        end
        checks++;
        if ({result, cout, ovf, zero, neg} !== {32'h00000043, 4'b0000}) begin
            errors++;
            $display("FAIL basic_add: got r=%h flags=%b want r=00000043 flags=0000",
                     result, {cout, ovf, zero, neg});
        end
    endtask

    task automatic test_overflow;
        int lat;
        logic [W+3:0] exp_pos, exp_neg;
`ifdef ADDSUB_SAT_EN
        exp_pos = {32'h7FFFFFFF, 4'b0100};
        exp_neg = {32'h80000000, 4'b1101};
`else
        exp_pos = {32'h80000000, 4'b0101};
        exp_neg = {32'h7FFFFFFF, 4'b1100};
`endif
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        checks++;
        if ({result, cout, ovf, zero, neg} !== exp_pos || lat != 3) begin
            errors++;
            $display("FAIL ovf_pos: got r=%h flags=%b lat=%0d want r=%h flags=%b lat=3",
                     result, {cout, ovf, zero, neg}, lat, exp_pos[W+3:4], exp_pos[3:0]);
        end
        run_op(32'h80000000, 32'h00000001, 1'b1, lat);
        checks++;
        if ({result, cout, ovf, zero, neg} !== exp_neg || lat != 3) begin
            errors++;
            $display("FAIL ovf_neg: got r=%h flags=%b lat=%0d want r=%h flags=%b lat=3",
                     result, {cout, ovf, zero, neg}, lat, exp_neg[W+3:4], exp_neg[3:0]);
        end
    endtask

    task automatic test_zero;
        int lat;
        run_op(32'h336FB7E5, 32'h336FB7E5, 1'b1, lat);
        checks++;
        if ({result, cout, ovf, zero, neg} !== {32'h00000000, 4'b1010} || lat != 3) begin
            errors++;
            $display("FAIL zero_sub: got r=%h flags=%b lat=%0d want r=00000000 flags=1010 lat=3",
                     result, {cout, ovf, zero, neg}, lat);
        end
    endtask

    // Beat i: a = 0x100*(i+1), b = i, sub = i[0]. Output ready low in cycles 6..8.
    task automatic test_back_to_back;
        logic [W-1:0] exp_r [8];
        logic [W-1:0] held;
        int idx, got;
        logic exp_rdy, exp_ov;
        exp_r[0] = 32'h00000100; exp_r[1] = 32'h000001FF;
        exp_r[2] = 32'h00000302; exp_r[3] = 32'h000003FD;
        exp_r[4] = 32'h00000504; exp_r[5] = 32'h000005FB;
        exp_r[6] = 32'h00000706; exp_r[7] = 32'h000007F9;
        idx = 0;
        got = 0;
        held = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c <= 8);
            if (idx < 8) begin
                in_valid = 1'b1;
                a = 32'h100 * (idx + 1);
                b = idx;
                sub = idx[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_rdy = (c < 6 || c > 8);
            exp_ov  = (c >= 4 && c <= 14);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL b2b_in_ready c=%0d: got %b want %b", c, in_ready, exp_rdy);
            end
            checks++;
            if (out_valid !== exp_ov) begin
                errors++;
                $display("FAIL b2b_out_valid c=%0d: got %b want %b", c, out_valid, exp_ov);
            end
            if (c == 6) held = result;
            if (c == 7 || c == 8) begin
                checks++;
                if (result !== held || result !== exp_r[2]) begin
                    errors++;
                    $display("FAIL b2b_hold c=%0d: got %h want %h", c, result, exp_r[2]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (got >= 8 || result !== exp_r[got]) begin
                    errors++;
                    $display("FAIL b2b_result #%0d: got %h want %h", got, result,
                             (got < 8) ? exp_r[got] : 32'h0);
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 8 || idx != 8) begin
            errors++;
            $display("FAIL b2b_count: got out=%0d in=%0d want 8 and 8", got, idx);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = k + 1; b = 32'h1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h00000002) begin
            errors++;
            $display("FAIL rst_mid_pre: got v=%b r=%h want v=1 r=00000002", out_valid, result);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got v=%b r=%h want v=0 r=0", out_valid, result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale k=%0d: got v=%b want 0", k, out_valid);
            end
        end
        run_op(32'h12345678, 32'h11111111, 1'b1, lat);
        checks++;
        if ({result, cout, ovf, zero, neg} !== {32'h01234567, 4'b1000} || lat != 3) begin
            errors++;
            $display("FAIL rst_mid_after: got r=%h flags=%b lat=%0d want r=01234567 flags=1000 lat=3",
                     result, {cout, ovf, zero, neg}, lat);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_zero;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
